// File: rtl/bin_to_ind_scan.sv
// bin_to_ind_scan: binary value in through a load/busy handshake, sequential
// double-dabble BCD conversion, multiplexed 7-segment scan over DIGITS digits.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank digits above the most
// significant nonzero nibble; digit 0 always shown).
module bin_to_ind_scan #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              tg,
  input  logic              rst,
  input  logic [WIDTH-1:0]  d,
  input  logic              load,
  output logic              busy,
  output logic [DIGITS-1:0] sel,
  output logic [6:0]        seg
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  localparam int BW = 4 * DIGITS;
  // Overflow limit is held at a width wide enough for both d and 10^DIGITS.
  localparam logic [63:0] LIMIT64 = pow10(DIGITS);
  localparam int LOG_W = $clog2(LIMIT64) + 1;
  localparam int CMP_W = (WIDTH > LOG_W) ? WIDTH : LOG_W;
  localparam logic [CMP_W-1:0] LIMIT = LIMIT64[CMP_W-1:0];
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  bin_reg, bin_next;
  logic [BW-1:0]     bcd_reg, bcd_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic [BW-1:0]     disp_reg, disp_next;
  logic              dovf_reg, dovf_next;
  logic [PW-1:0]     presc_reg;
  logic [IW-1:0]     idx_reg;

  logic [CMP_W-1:0]      d_ext;
  logic                  ovf_in;
  logic [BW-1:0]         bcd_adj;
  logic [BW+WIDTH-1:0]   shifted;
  logic [6:0]            seg_dig [DIGITS];

  assign d_ext   = CMP_W'(d);
  assign ovf_in  = (d_ext >= LIMIT);
  assign shifted = {bcd_adj, bin_reg} << 1;

  // Add-3 correction applied to every nibble that is 5 or more.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Converter state and datapath registers.
  always_ff @(posedge tg) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      disp_reg  <= '0;
      dovf_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      disp_reg  <= disp_next;
      dovf_reg  <= dovf_next;
    end
  end

  // Converter next-state: capture on load, one iteration per CONV cycle,
  // publish result on the last iteration edge.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    disp_next  = disp_reg;
    dovf_next  = dovf_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          bin_next   = d;
          bcd_next   = '0;
          cnt_next   = '0;
          ovf_next   = ovf_in;
          state_next = CONV;
        end
      end
      CONV: begin
        bcd_next = shifted[BW+WIDTH-1:WIDTH];
        bin_next = shifted[WIDTH-1:0];
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          disp_next  = shifted[BW+WIDTH-1:WIDTH];
          dovf_next  = ovf_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == CONV);

  // Refresh prescaler and digit index, free running after reset.
  always_ff @(posedge tg) begin
    if (rst) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (presc_reg == PW'(REFRESH_DIV - 1)) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // upper_zero[i]: nibble i and every nibble above it are zero.
  logic [DIGITS-1:0] upper_zero;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign upper_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0) & upper_zero[gi+1];
      end
      if (gi == 0) begin : g_d0
        assign seg_dig[gi] = seg7(disp_reg[4*gi +: 4]);
      end else begin : g_dn
        assign seg_dig[gi] = upper_zero[gi] ? 7'h00 : seg7(disp_reg[4*gi +: 4]);
      end
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign seg_dig[gi] = seg7(disp_reg[4*gi +: 4]);
    end
  endgenerate
`endif

  assign sel = ~(DIGITS'(1) << idx_reg);
  assign seg = dovf_reg ? 7'h40 : seg_dig[idx_reg];

endmodule

// File: tb/tb_bin_to_ind_scan.sv
// Randomized self-checking bench for bin_to_ind_scan (DIGITS=4, WIDTH=14,
// REFRESH_DIV=4) against a decimal-arithmetic display model.
module tb_bin_to_ind_scan;

  logic        tg = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] d = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [3:0]  sel;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int shown  = 0;
  int scan_cnt = 0;
  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bin_to_ind_scan #(.DIGITS(4), .WIDTH(14), .REFRESH_DIV(4)) dut (
    .tg(tg), .rst(rst), .d(d), .load(load), .busy(busy), .sel(sel), .seg(seg)
  );

  always #5 tg = ~tg;

  // Cycles since the last reset edge; the scan position follows from it.
  always @(posedge tg) begin
    if (rst) scan_cnt <= 0;
    else     scan_cnt <= scan_cnt + 1;
  end

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v >= 10000) return 7'h40;
`ifdef LEAD_ZERO_BLANK_EN
    if (i > 0 && v < p) return 7'h00;
`endif
    return codes[(v / p) % 10];
  endfunction

  function automatic logic [3:0] exp_sel();
    int idx;
    idx = (scan_cnt / 4) % 4;
    return ~(4'b0001 << idx);
  endfunction

  task automatic check_scan(input string tag);
    int idx;
    idx = (scan_cnt / 4) % 4;
    checks++;
    if (sel !== exp_sel()) begin
      errors++;
      $display("FAIL %s_sel got %b want %b", tag, sel, exp_sel());
    end
    checks++;
    if (seg !== exp_seg(shown, idx)) begin
      errors++;
      $display("FAIL %s_seg value %0d digit %0d got %h want %h", tag, shown, idx, seg, exp_seg(shown, idx));
    end
  endtask

  // Idle observation: busy low, scan and segments follow the model.
  task automatic check_display(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy got %b want 0", tag, busy);
      end
      check_scan(tag);
      @(negedge tg);
    end
  endtask

  // Starts a conversion at the current negedge and follows it to completion.
  // pulse: assert a second load mid-conversion; abort: reset at CONV cycle 7.
  task automatic start_conv(input int v, input bit pulse, input bit abort);
    int n;
    d = v[13:0];
    load = 1'b1;
    @(negedge tg);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (abort && n == 7) begin
        rst = 1'b1;
        load = 1'b1;
        d = 14'd9999;
        @(negedge tg);
        rst = 1'b0;
        load = 1'b0;
        shown = 0;
        $display("reset during conversion of %0d", v);
        return;
      end
      check_scan("hold");
      if (pulse && n == 5) begin
        d = 14'd4321;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      n++;
      @(negedge tg);
    end
    load = 1'b0;
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL busy_len d=%0d got %0d want 14", v, n);
    end
    shown = v;
    $display("load d=%0d busy cycles %0d", v, n);
  endtask

  task automatic do_load(input int v);
    start_conv(v, 1'b0, 1'b0);
    check_display(16, "disp");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge tg);
    rst = 1'b0;
    shown = 0;
    check_display(17, "reset");
  endtask

  task automatic test_conversion();
    do_load(1234);
    do_load(9999);
    do_load(7);
    do_load(0);
    for (int i = 0; i < 12; i++) do_load(int'($urandom_range(9999, 0)));
  endtask

  task automatic test_overflow();
    do_load(10000);
    do_load(16383);
    do_load(int'($urandom_range(16383, 10000)));
    do_load(5);
  endtask

  task automatic test_handshake();
    start_conv(1234, 1'b1, 1'b0);
    check_display(16, "ignored");
  endtask

  task automatic test_back_to_back();
    start_conv(1234, 1'b0, 1'b0);
    start_conv(4321, 1'b0, 1'b0);
    start_conv(int'($urandom_range(16383, 0)), 1'b0, 1'b0);
    check_display(16, "b2b");
  endtask

  task automatic test_reset_mid();
    start_conv(1234, 1'b0, 1'b1);
    check_display(20, "abort");
    do_load(int'($urandom_range(9999, 0)));
  endtask

  initial begin
    @(negedge tg);
    test_reset();
    test_conversion();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_ind_scan.md
# bin_to_ind_scan

Parametrised multiplexed 7-segment display driver: accepts an unsigned binary value through a load/busy handshake, converts it to BCD with a sequential shift-add-3 engine, and scans it across `DIGITS` common-select digits at a programmable refresh rate. It replaces the fixed 4-digit, 14-bit driver in the display path. It sits between any binary data source and the board's select and segment pins. The display holds the last completed value while a new conversion runs, so partial results are never shown.

## Interface
- `DIGITS`, 4: number of display digits (1..8).
- `WIDTH`, 14: binary input width (1..32).
- `REFRESH_DIV`, 1000: clocks per digit slot (≥2).

- `tg`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  WIDTH  unsigned value to display.
- `load`  in  1  request; accepted on a rising edge where `busy`=0.
- `busy`  out  1  conversion in progress.
- `sel`  out  DIGITS  active-low digit selects; `sel[0]` is the least-significant digit.
- `seg`  out  7  active-high segments: bit0=a top, 1=b upper-right, 2=c lower-right, 3=d bottom, 4=e lower-left, 5=f upper-left, 6=g middle.

## Operation
- Converter FSM states:
  - IDLE: `busy`=0.
  - On `load`=1: capture `d` into the shift register and clear the BCD accumulator (4·DIGITS bits). Capture the overflow flag (`d` ≥ 10^DIGITS). Go to CONV.
  - CONV: one double-dabble iteration per clock. Each BCD nibble ≥5 gets +3, then the whole register shifts left 1.
  - After the WIDTH-th iteration, copy the accumulator and overflow flag into the display register in the same edge. Return to IDLE.
- `load` while `busy`=1 is ignored, not queued.
- Scan: the prescaler counts 0..REFRESH_DIV-1. At terminal count the digit index increments and wraps from DIGITS-1 to 0. Scanning is independent of conversion.
- `sel` = all ones except bit[index], which is 0.
- `seg` = 7-segment code of display-register nibble[index]. Codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
- Overflow latched: every digit shows 7'h40 (dash) until the next completed conversion without overflow.
- Arithmetic: the overflow compare uses a constant of width max(WIDTH, ceil(log2(10^DIGITS))+1), with no truncation. Nibbles above DIGITS are never produced.

## Timing
- Reset values:
  - `busy`=0, FSM=IDLE, display register=0, overflow=0.
  - Prescaler=0, index=0.
  - Hence `sel`={1…1,0} and `seg`=7'h3F.
- `rst` has priority over `load` in the same cycle.
- `rst` during CONV aborts the conversion. The display is cleared to 0, not the old value.
- Handshake: `load` sampled at edge k → `busy`=1 after edge k. `busy` stays high for exactly WIDTH cycles and falls at edge k+WIDTH. The new display value is visible from that same edge.
- `load` may be re-asserted in the cycle `busy` drops. It is accepted at the next edge, giving back-to-back conversions every WIDTH+1 cycles.
- `sel`/`seg` change only on prescaler terminal-count edges or display-register update edges. Each digit is active for exactly REFRESH_DIV cycles.
- Wrap-around: the index goes DIGITS-1 → 0 without a gap cycle.

## Configuration
- `LEAD_ZERO_BLANK_EN` defined: every digit above the most-significant nonzero nibble outputs `seg`=0. Digit 0 is always shown, so value 0 displays a single "0". Overflow dashes are unaffected.
- Not defined: all DIGITS digits are always driven, leading zeros shown as 7'h3F.

## Test plan
(All cases use DIGITS=4, WIDTH=14, REFRESH_DIV=4.)
- Reset: assert `rst` 2 cycles → `busy`=0, `sel`=4'b1110, `seg`=7'h3F. After 4 clocks `sel`=4'b1101. After 16 clocks it is back to 4'b1110.
- Conversion: `load` with `d`=1234 → `busy` high exactly 14 cycles. Then slots sel[0..3] show 7'h66, 7'h4F, 7'h5B, 7'h06. Boundary `d`=9999 → four 7'h6F.
- Overflow: `d`=10000 and `d`=16383 → all four slots 7'h40. A following `d`=5 clears the dashes.
- Handshake: load 1234, then pulse `load` with 4321 while `busy`=1 → pulse ignored, display ends at 1234. Re-load on the `busy`-fall cycle → accepted, 4321 shown WIDTH+1 cycles later.
- Reset mid-operation: `rst` at CONV cycle 7 → `busy`=0 next edge, all digits 7'h3F, index=0. A `load` asserted together with `rst` is ignored.
- Macro: `d`=7 with `LEAD_ZERO_BLANK_EN` → sel[0] 7'h07, sel[1..3] 7'h00. `d`=0 → sel[0] 7'h3F, others 0. Without the macro, `d`=7 → 07, 3F, 3F, 3F.
